// File: rtl/hazard_stall_unit_pkg.sv
// Shared definitions for the hazard stall/flush controller.
//   stallState_t : FSM state encodings
//   REG_ZERO     : architectural zero register, never a hazard source
package hazard_stall_unit_pkg;

    typedef enum logic [1:0] {
        RUN        = 2'd0,
        LOAD_STALL = 2'd1,
        MEM_WAIT   = 2'd2
    } stallState_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_stall_unit_load_use_detect.sv
// Purely combinational load-use hazard compare.
// Ports:
//   idExMemRead  in  1  instruction in EX is a load
//   idExRt       in  5  load destination register
//   ifIdRs       in  5  ID source rs
//   ifIdRt       in  5  ID source rt
//   ifIdUsesRt   in  1  ID instruction actually reads rt
//   loadUse      out 1  ID instruction needs the load result next cycle
module load_use_detect
    import hazard_stall_unit_pkg::*;
(
    input  logic       idExMemRead,
    input  logic [4:0] idExRt,
    input  logic [4:0] ifIdRs,
    input  logic [4:0] ifIdRt,
    input  logic       ifIdUsesRt,
    output logic       loadUse
);

    // rt only counts when the ID instruction really reads it, otherwise an
    // I-type destination field would cause false stalls.
    assign loadUse = idExMemRead && (idExRt != REG_ZERO) &&
                     ((idExRt == ifIdRs) || (ifIdUsesRt && (idExRt == ifIdRt)));

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the hazards forwarding cannot resolve:
// load-use bubbles, data-memory wait freezes and taken-branch flushes.
// Ports:
//   clk, rst_n           clock and synchronous active-low reset
//   ID_EX_MemRead/RegisterRt, IF_ID_RegisterRs/Rt, IF_ID_UsesRt : load-use inputs
//   EX_MEM_MemReq, mem_ready : data memory handshake
//   branch_taken         branch resolved taken in EX
//   pc_write, IF_ID_Write     front-end enables
//   ID_EX_Bubble, IF_ID_Flush controls for bubble insertion / squash
//   pipe_freeze          hold ID/EX, EX/MEM, MEM/WB
//   mem_timeout          sticky, memory wait exceeded MAX_WAIT cycles
//   stall_count          saturating count of cycles with pc_write low
//
// state      | meaning
// RUN        | normal flow; may start a freeze, flush or load-use stall
// LOAD_STALL | single bubble cycle after a load-use hit
// MEM_WAIT   | pipeline frozen until mem_ready
module hazard_stall_unit
    import hazard_stall_unit_pkg::*;
#(
    parameter int CNT_W    = 32,
    parameter int MAX_WAIT = 16
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ID_EX_MemRead,
    input  logic [4:0]       ID_EX_RegisterRt,
    input  logic [4:0]       IF_ID_RegisterRs,
    input  logic [4:0]       IF_ID_RegisterRt,
    input  logic             IF_ID_UsesRt,
    input  logic             EX_MEM_MemReq,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             pc_write,
    output logic             IF_ID_Write,
    output logic             ID_EX_Bubble,
    output logic             IF_ID_Flush,
    output logic             pipe_freeze,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_count
);

    localparam int WAIT_W = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    stallState_t       stateQ, stateD;
    logic [WAIT_W-1:0] waitCntQ, waitCntD;
    logic              brPendQ, brPendD;
    logic              timeoutQ, timeoutD;
    logic [CNT_W-1:0]  stallCntQ;

    logic loadUse;
    logic memStall;
    logic branchEff;
    logic pcWr, ifIdWr, bubble, flush, freeze;

    load_use_detect uLoadUse (
        .idExMemRead (ID_EX_MemRead),
        .idExRt      (ID_EX_RegisterRt),
        .ifIdRs      (IF_ID_RegisterRs),
        .ifIdRt      (IF_ID_RegisterRt),
        .ifIdUsesRt  (IF_ID_UsesRt),
        .loadUse     (loadUse)
    );

    assign memStall  = EX_MEM_MemReq && !mem_ready;
    // A branch that arrived together with a freeze is replayed as a flush
    // in the first unfrozen cycle.
    assign branchEff = branch_taken || brPendQ;

    always_comb begin
        stateD   = stateQ;
        waitCntD = waitCntQ;
        brPendD  = brPendQ;
        timeoutD = timeoutQ;
        pcWr     = 1'b1;
        ifIdWr   = 1'b1;
        bubble   = 1'b0;
        flush    = 1'b0;
        freeze   = 1'b0;

        case (stateQ)
            RUN, LOAD_STALL: begin
                if (memStall) begin
                    freeze   = 1'b1;
                    pcWr     = 1'b0;
                    ifIdWr   = 1'b0;
                    brPendD  = branchEff;
                    waitCntD = '0;
                    stateD   = MEM_WAIT;
                end else if (branchEff) begin
                    // Squashes any load-use victim, so no stall is needed.
                    flush   = 1'b1;
                    bubble  = 1'b1;
                    brPendD = 1'b0;
                    stateD  = RUN;
                end else if ((stateQ == RUN) && loadUse) begin
                    pcWr   = 1'b0;
                    ifIdWr = 1'b0;
                    bubble = 1'b1;
                    stateD = LOAD_STALL;
                end else begin
                    stateD = RUN;
                end
            end

            MEM_WAIT: begin
                freeze = 1'b1;
                pcWr   = 1'b0;
                ifIdWr = 1'b0;
                if (mem_ready) begin
                    waitCntD = '0;
                    stateD   = RUN;
                end else begin
                    if (waitCntQ != WAIT_MAX) begin
                        waitCntD = waitCntQ + 1'b1;
                    end
                    timeoutD = timeoutQ || (waitCntD == WAIT_MAX);
                end
            end

            default: begin
                stateD = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stateQ    <= RUN;
            waitCntQ  <= '0;
            brPendQ   <= 1'b0;
            timeoutQ  <= 1'b0;
            stallCntQ <= '0;
        end else begin
            stateQ   <= stateD;
            waitCntQ <= waitCntD;
            brPendQ  <= brPendD;
            timeoutQ <= timeoutD;
            if (!pcWr && (stallCntQ != '1)) begin
                stallCntQ <= stallCntQ + 1'b1;
            end
        end
    end

    // While reset is held the front end runs freely and everything else is
    // quiet, independent of whatever the registers hold before the edge.
    assign pc_write     = rst_n ? pcWr   : 1'b1;
    assign IF_ID_Write  = rst_n ? ifIdWr : 1'b1;
    assign ID_EX_Bubble = rst_n && bubble;
    assign IF_ID_Flush  = rst_n && flush;
    assign pipe_freeze  = rst_n && freeze;
    assign mem_timeout  = rst_n && timeoutQ;
    assign stall_count  = rst_n ? stallCntQ : '0;

endmodule
